// File: rtl/pc_unit.sv
// Program counter unit: sequential increment, redirect, trap/mret, and a HALT
// state entered on a misaligned redirect and left via resume.
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int              IALIGN       = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            trap_valid,
   input  logic            mret_valid,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus,
   output logic [XLEN-1:0] epc,
   output logic            misaligned,
   output logic            halted,
   output logic [XLEN-1:0] advance_count
);

   localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
   localparam logic [XLEN-1:0] ONE        = XLEN'(1);
   localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t          state_r, next_state_s;
   logic [XLEN-1:0] pc_r, pc_next_s;
   logic [XLEN-1:0] epc_r, epc_next_s;
   logic [XLEN-1:0] count_r, count_next_s;
   logic            mis_r, mis_next_s;
   logic            advance_s;
   logic            target_ok_s;

   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return (addr & ALIGN_MASK) == ZERO;
   endfunction

   assign target_ok_s = is_aligned(redirect_target);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic: only a misaligned redirect halts, only resume restarts
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (!trap_valid && !mret_valid && redirect_valid && !target_ok_s) begin
               next_state_s = ST_HALT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_HALT: begin
            if (resume) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         default: next_state_s = ST_RUN;
      endcase
   end

   // Datapath next values in priority order trap > mret > redirect > stall > increment
   always_comb begin
      pc_next_s  = pc_r;
      epc_next_s = epc_r;
      mis_next_s = mis_r;
      advance_s  = 1'b0;
      case (state_r)
         ST_RUN: begin
            if (trap_valid) begin
               epc_next_s = pc_r;
               pc_next_s  = TRAP_VECTOR;
               advance_s  = 1'b1;
            end else if (mret_valid) begin
               pc_next_s  = epc_r;
               advance_s  = 1'b1;
            end else if (redirect_valid) begin
               if (target_ok_s) begin
                  pc_next_s  = redirect_target;
                  advance_s  = 1'b1;
               end else begin
                  epc_next_s = pc_r;
                  mis_next_s = 1'b1;
               end
            end else if (stall) begin
               pc_next_s  = pc_r;
            end else begin
               pc_next_s  = pc_r + STEP;
               advance_s  = 1'b1;
            end
         end
         ST_HALT: begin
            if (resume) begin
               pc_next_s  = TRAP_VECTOR;
               mis_next_s = 1'b0;
               advance_s  = 1'b1;
            end else begin
               pc_next_s  = pc_r;
            end
         end
         default: begin
            pc_next_s  = pc_r;
         end
      endcase
      count_next_s = advance_s ? (count_r + ONE) : count_r;
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r    <= RESET_VECTOR;
         epc_r   <= ZERO;
         mis_r   <= 1'b0;
         count_r <= ZERO;
      end else begin
         pc_r    <= pc_next_s;
         epc_r   <= epc_next_s;
         mis_r   <= mis_next_s;
         count_r <= count_next_s;
      end
   end

   // Outputs
   always_comb begin
      pc            = pc_r;
      pc_plus       = pc_r + STEP;
      epc           = epc_r;
      misaligned    = mis_r;
      halted        = (state_r == ST_HALT);
      advance_count = count_r;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, then a randomized
// run against an independent reference model, both through a scoreboard queue.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset, stall, redirect_valid, trap_valid, mret_valid, resume;
   logic [31:0] redirect_target;
   logic [31:0] pc, pc_plus, epc, advance_count;
   logic        misaligned, halted;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .trap_valid(trap_valid), .mret_valid(mret_valid), .resume(resume),
      .pc(pc), .pc_plus(pc_plus), .epc(epc), .misaligned(misaligned),
      .halted(halted), .advance_count(advance_count)
   );

   typedef struct {
      logic        rst, stl, rv;
      logic [31:0] tgt;
      logic        trp, mrt, res;
      logic [31:0] e_pc, e_epc;
      logic        e_mis, e_halt;
      logic [31:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc, epc;
      logic        mis, halt;
      logic [31:0] cnt;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, stl, rv, input logic [31:0] tgt,
                               input logic trp, mrt, res,
                               input logic [31:0] e_pc, e_epc,
                               input logic e_mis, e_halt, input logic [31:0] e_cnt);
      vec_t v;
      v.rst = rst; v.stl = stl; v.rv = rv; v.tgt = tgt;
      v.trp = trp; v.mrt = mrt; v.res = res;
      v.e_pc = e_pc; v.e_epc = e_epc; v.e_mis = e_mis; v.e_halt = e_halt; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, push its expectation, compare after the edge.
   task automatic step(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      reset = v.rst; stall = v.stl; redirect_valid = v.rv; redirect_target = v.tgt;
      trap_valid = v.trp; mret_valid = v.mrt; resume = v.res;
      sb.push_back('{v.e_pc, v.e_epc, v.e_mis, v.e_halt, v.e_cnt});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".pc"}, pc, e.pc);
      chk({tag, ".pc_plus"}, pc_plus, e.pc + 32'd4);
      chk({tag, ".epc"}, epc, e.epc);
      chk({tag, ".misaligned"}, {31'd0, misaligned}, {31'd0, e.mis});
      chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e.halt});
      chk({tag, ".count"}, advance_count, e.cnt);
   endtask

   // Reference model state for the random phase
   logic [31:0] m_pc, m_epc, m_cnt;
   logic        m_mis, m_halt;

   task automatic model(inout vec_t v);
      if (v.rst) begin
         m_pc = 32'h0; m_epc = 32'h0; m_mis = 1'b0; m_halt = 1'b0; m_cnt = 32'h0;
      end else if (m_halt) begin
         if (v.res) begin
            m_pc = 32'h100; m_mis = 1'b0; m_halt = 1'b0; m_cnt = m_cnt + 32'd1;
         end
      end else if (v.trp) begin
         m_epc = m_pc; m_pc = 32'h100; m_cnt = m_cnt + 32'd1;
      end else if (v.mrt) begin
         m_pc = m_epc; m_cnt = m_cnt + 32'd1;
      end else if (v.rv) begin
         if (v.tgt[1:0] == 2'b00) begin
            m_pc = v.tgt; m_cnt = m_cnt + 32'd1;
         end else begin
            m_epc = m_pc; m_mis = 1'b1; m_halt = 1'b1;
         end
      end else if (!v.stl) begin
         m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
      end
      v.e_pc = m_pc; v.e_epc = m_epc; v.e_mis = m_mis; v.e_halt = m_halt; v.e_cnt = m_cnt;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      trap_valid = 1'b0; mret_valid = 1'b0; resume = 1'b0;

      //              rst   stl   rv    tgt            trp   mrt   res   pc             epc           mis   halt  cnt
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'd0));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'd0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        32'h0,  1'b0, 1'b0, 32'd1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8,        32'h0,  1'b0, 1'b0, 32'd2));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hC,        32'h0,  1'b0, 1'b0, 32'd3));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 1'b0, 1'b0, 32'h8,        32'h0,  1'b0, 1'b0, 32'd4));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 1'b0, 1'b0, 32'h40,       32'h0,  1'b0, 1'b0, 32'd5));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h40,       32'h0,  1'b0, 1'b0, 32'd5));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44,       32'h0,  1'b0, 1'b0, 32'd6));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h80,       1'b1, 1'b1, 1'b0, 32'h100,      32'h44, 1'b0, 1'b0, 32'd7));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44,       32'h44, 1'b0, 1'b0, 32'd8));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 1'b0, 32'h20,       32'h44, 1'b0, 1'b0, 32'd9));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h52,       1'b0, 1'b0, 1'b0, 32'h20,       32'h20, 1'b1, 1'b1, 32'd9));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h20,       32'h20, 1'b1, 1'b1, 32'd9));
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'h40,       1'b0, 1'b1, 1'b0, 32'h20,       32'h20, 1'b1, 1'b1, 32'd9));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h100,      32'h20, 1'b0, 1'b0, 32'd10));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h104,      32'h20, 1'b0, 1'b0, 32'd11));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h20, 1'b0, 1'b0, 32'd12));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h20, 1'b0, 1'b0, 32'd13));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,  1'b1, 1'b1, 32'd13));
      tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,  1'b0, 1'b0, 32'd0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        32'h0,  1'b0, 1'b0, 32'd1));
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h100,      32'h4,  1'b0, 1'b0, 32'd2));
      tbl.push_back(mk(1'b1, 1'b0, 1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 32'h0,        32'h0,  1'b0, 1'b0, 32'd0));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h100,      32'h0,  1'b0, 1'b0, 32'd1));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h104,      32'h0,  1'b0, 1'b0, 32'd2));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h100,      32'h104, 1'b0, 1'b0, 32'd3));
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 1'b1, 1'b0, 32'h104,      32'h104, 1'b0, 1'b0, 32'd4));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Hand sequence: halt, then reset while halted with resume also asserted
      step(mk(1'b0, 1'b0, 1'b1, 32'h106, 1'b0, 1'b0, 1'b0, 32'h104, 32'h104, 1'b1, 1'b1, 32'd4), "halt_a");
      step(mk(1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h104, 32'h104, 1'b1, 1'b1, 32'd4), "halt_b");
      step(mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0,   32'h0,   1'b0, 1'b0, 32'd0), "halt_rst");

      // Randomized run against the reference model
      v = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
      model(v);
      step(v, "rnd_rst");
      for (int n = 0; n < 300; n++) begin
         v.rst = ($urandom_range(0, 49) == 0);
         v.stl = ($urandom_range(0, 3) == 0);
         v.rv  = ($urandom_range(0, 4) == 0);
         v.tgt = $urandom();
         if ($urandom_range(0, 5) != 0) v.tgt[1:0] = 2'b00;
         v.trp = ($urandom_range(0, 9) == 0);
         v.mrt = ($urandom_range(0, 9) == 0);
         v.res = ($urandom_range(0, 3) == 0);
         model(v);
         step(v, $sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
